// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one or two stop bits.
// Bit timing comes from an external baud_tick strobe; baud_run enables that generator while a frame is in flight.
module uart_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 baud_tick,
    output logic                 baud_run,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state, w_state_next;
    logic [DATA_BITS-1:0]   r_data, w_data_next;
    logic                   r_par_en, w_par_en_next;
    logic                   r_par_odd, w_par_odd_next;
    logic                   r_two_stop, w_two_stop_next;
    logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_next;
    logic                   r_stop_cnt, w_stop_cnt_next;
    logic                   r_tx_out, w_tx_out_next;
    logic                   r_done, w_done_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx_out   <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_par_en   <= w_par_en_next;
            r_par_odd  <= w_par_odd_next;
            r_two_stop <= w_two_stop_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx_out   <= w_tx_out_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_par_en_next   = r_par_en;
        w_par_odd_next  = r_par_odd;
        w_two_stop_next = r_two_stop;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_next    = S_START;
                    w_data_next     = tx_data;
                    w_par_en_next   = parity_en;
                    w_par_odd_next  = parity_odd;
                    w_two_stop_next = two_stop;
                    w_bit_idx_next  = '0;
                    w_stop_cnt_next = 1'b0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_next    = r_par_en ? S_PARITY : S_STOP;
                        w_stop_cnt_next = 1'b0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    w_state_next    = S_STOP;
                    w_stop_cnt_next = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    // The second stop bit is only owed when two_stop was latched.
                    if (!r_two_stop || r_stop_cnt) begin
                        w_state_next    = S_IDLE;
                        w_stop_cnt_next = 1'b0;
                        w_bit_idx_next  = '0;
                        w_done_next     = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx_out comes straight from a flop.
    always_comb begin
        w_tx_out_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_out_next = 1'b0;
            S_DATA:   w_tx_out_next = w_data_next[w_bit_idx_next];
            S_PARITY: w_tx_out_next = (^r_data) ^ r_par_odd;
            default:  w_tx_out_next = 1'b1;
        endcase
    end

    assign tx_ready = (r_state == S_IDLE);
    assign tx_busy  = ~tx_ready;
    assign baud_run = tx_busy;
    assign tx_out   = r_tx_out;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: constant frame vectors, back-to-back, reset abort and random frames
// checked against a frame-level model built from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       baud_tick;
    logic       baud_run;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.DATA_BITS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .baud_tick  (baud_tick),
        .baud_run   (baud_run),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        po;
        logic        ts;
        logic [7:0]  mut;
        logic [11:0] exp_bits;
        int          exp_len;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference framing: start 0, data LSB first, optional parity (even count of ones incl. parity
    // unless odd selected), then one or two stop bits of 1.
    function automatic logic [11:0] model_bits(input logic [7:0] d, input logic pe, input logic po,
                                               input logic ts);
        logic [11:0] b;
        int          n;
        b = 12'hFFF;
        b[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i];
            n++;
        end
        if (pe) begin
            b[n] = (($countones(d) % 2) == 1) ^ po;
            n++;
        end
        return b;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where the start bit is on the line.
    task automatic accept(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                          input logic [7:0] mut, input logic hold);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        tx_valid   = 1'b1;
        chk("ready_before_accept", tx_ready, 1'b1);
        @(negedge clock);
        chk("start_bit_latency", tx_out, 1'b0);
        chk("busy_after_accept", tx_busy, 1'b1);
        chk("baud_run_after_accept", baud_run, 1'b1);
        tx_data = mut;
        if (!hold) begin
            tx_valid   = 1'b0;
            parity_en  = ~pe;
            parity_odd = ~po;
            two_stop   = ~ts;
        end
    endtask

    // Walks the frame tick by tick from the start bit; returns at the negedge after the final tick.
    task automatic check_frame(input logic [11:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
                chk("bit_hold", tx_out, bits[i]);
                @(negedge clock);
            end
            chk("line_bit", tx_out, bits[i]);
            chk("no_early_done", tx_done, 1'b0);
            chk("run_in_frame", baud_run, 1'b1);
            baud_tick = 1'b1;
            @(negedge clock);
            baud_tick = 1'b0;
        end
        chk("done_pulse", tx_done, 1'b1);
        chk("ready_at_done", tx_ready, 1'b1);
        chk("run_drop_at_done", baud_run, 1'b0);
        chk("idle_line", tx_out, 1'b1);
        $display("frame bits=%03h len=%0d done=%b ready=%b", bits, len, tx_done, tx_ready);
    endtask

    task automatic after_frame();
        @(negedge clock);
        chk("done_one_cycle", tx_done, 1'b0);
        chk("idle_ready", tx_ready, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h5A, 12'h34A, 10};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 12'h54A, 11};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hFF, 12'h74A, 11};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 12'h600, 11};
        tbl[4] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'hEE, 12'h424, 11};

        reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; baud_tick = 1'b0;
        #3;
        chk("rst_tx_out", tx_out, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_run", baud_run, 1'b0);
        repeat (2) @(negedge clock);
        tx_valid = 1'b1;
        chk("rst_hold_ready", tx_ready, 1'b1);
        chk("rst_hold_line", tx_out, 1'b1);
        reset = 1'b0;

        // First frame is presented in the same cycle reset drops: accepted on the first edge.
        for (int k = 0; k < 5; k++) begin
            accept(tbl[k].d, tbl[k].pe, tbl[k].po, tbl[k].ts, tbl[k].mut, 1'b0);
            check_frame(tbl[k].exp_bits, tbl[k].exp_len);
            after_frame();
        end

        // baud_tick in IDLE must not start anything.
        repeat (3) begin
            baud_tick = 1'b1;
            @(negedge clock);
            chk("idle_tick_ready", tx_ready, 1'b1);
            chk("idle_tick_line", tx_out, 1'b1);
            chk("idle_tick_run", baud_run, 1'b0);
        end
        baud_tick = 1'b0;

        // Back-to-back: tx_valid stays high, second byte taken in the tx_done cycle.
        accept(8'h55, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b1);
        check_frame(12'h2AA, 10);
        @(negedge clock);
        chk("b2b_start_bit", tx_out, 1'b0);
        chk("b2b_busy", tx_busy, 1'b1);
        chk("b2b_done_low", tx_done, 1'b0);
        tx_valid = 1'b0;
        check_frame(12'h21E, 10);
        after_frame();

        // Reset in the middle of a 0xFF frame.
        accept(8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        repeat (4) begin
            baud_tick = 1'b1;
            @(negedge clock);
            baud_tick = 1'b0;
        end
        chk("pre_abort_data", tx_out, 1'b1);
        chk("pre_abort_busy", tx_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort_line", tx_out, 1'b1);
        chk("abort_ready", tx_ready, 1'b1);
        chk("abort_run", baud_run, 1'b0);
        chk("abort_done", tx_done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            baud_tick = 1'b1;
            @(negedge clock);
            chk("abort_no_done", tx_done, 1'b0);
            chk("abort_stays_idle", tx_ready, 1'b1);
        end
        baud_tick = 1'b0;
        $display("reset abort checked line=%b ready=%b", tx_out, tx_ready);
        accept(8'h3C, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
        check_frame(12'h278, 10);
        after_frame();

        // Random frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [7:0] d;
            logic       pe, po, ts;
            d  = 8'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            ts = 1'($urandom);
            accept(d, pe, po, ts, 8'($urandom), 1'b0);
            check_frame(model_bits(d, pe, po, ts), 10 + int'(pe) + int'(ts));
            after_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
